// File: rtl/hs_arb_pkg.sv
// Shared types and default constants for the hiscore RAM arbiter.
// The grant watchdog is compiled in only when HS_ARB_WATCHDOG_EN is defined.
package hs_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSING,
    ST_GRANT,
    ST_RELEASE,
    ST_COOLDOWN
  } hs_arb_state_t;

  localparam int unsigned HS_ARB_SETTLE_CYCLES_DEF = 4;
  localparam int unsigned HS_ARB_MIN_CPU_CYCLES_DEF = 16;
  localparam int unsigned HS_ARB_WDOG_CYCLES_DEF = 65535;

  // Counter width for a count of n cycles, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hs_arb_watchdog.sv
// Grant-duration watchdog: flags the last permitted grant cycle so the
// arbiter can force a release. Instantiated only under HS_ARB_WATCHDOG_EN.
module hs_arb_watchdog
  import hs_arb_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = HS_ARB_WDOG_CYCLES_DEF
) (
  input  logic clk_49m,
  input  logic reset,
  input  logic active,
  output logic expired
);

  localparam int unsigned WDOG_EFF = (WDOG_CYCLES == 0) ? 1 : WDOG_CYCLES;
  localparam int unsigned WW = cnt_width(WDOG_EFF);
  localparam logic [WW-1:0] LAST = WW'(WDOG_EFF - 1);

  logic [WW-1:0] cnt;

  always_ff @(posedge clk_49m) begin
    if (reset || !active) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + WW'(1);
    end
  end

  assign expired = active && (cnt == LAST);

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares the game work-RAM port between the CPU and the hiscore engine by
// pausing the CPU around each grant. Optional grant watchdog: HS_ARB_WATCHDOG_EN.
module hiscore_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = HS_ARB_SETTLE_CYCLES_DEF,
  parameter int unsigned MIN_CPU_CYCLES = HS_ARB_MIN_CPU_CYCLES_DEF,
  parameter int unsigned WDOG_CYCLES    = HS_ARB_WDOG_CYCLES_DEF
) (
  input  logic        clk_49m,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        user_pause,
  input  logic        hs_req,
  input  logic [15:0] hs_addr,
  input  logic [7:0]  hs_wdata,
  input  logic        hs_we,
  output logic        hs_grant,
  output logic [7:0]  hs_rdata,
  output logic        hs_rvalid,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        cpu_pause,
  output logic        collision,
  output logic        wdog_err
);

  localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam int unsigned COOL_EFF   = (MIN_CPU_CYCLES == 0) ? 1 : MIN_CPU_CYCLES;
  localparam int unsigned SW = cnt_width(SETTLE_EFF);
  localparam int unsigned CW = cnt_width(COOL_EFF);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_EFF - 1);
  localparam logic [CW-1:0] COOL_LOAD   = CW'(COOL_EFF - 1);

  hs_arb_state_t state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_cnt_nxt;
  logic [CW-1:0] cool_cnt, cool_cnt_nxt;
  logic          rvalid_q;
  logic          collision_q;
  logic          granted;
  logic          busy;
  logic          wdog_expire;
  logic          req_block;
  logic          wdog_err_int;

`ifdef HS_ARB_WATCHDOG_EN
  logic block_q;
  logic wdog_err_q;

  hs_arb_watchdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk_49m (clk_49m),
    .reset   (reset),
    .active  (granted),
    .expired (wdog_expire)
  );

  // After a forced release the engine must drop hs_req before it is served again.
  always_ff @(posedge clk_49m) begin
    if (reset) begin
      block_q    <= 1'b0;
      wdog_err_q <= 1'b0;
    end else if (wdog_expire) begin
      block_q    <= 1'b1;
      wdog_err_q <= 1'b1;
    end else if (!hs_req) begin
      block_q    <= 1'b0;
    end
  end

  assign req_block    = block_q;
  assign wdog_err_int = wdog_err_q;
`else
  // The grant limit has no effect in this build.
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_expire  = 1'b0;
  assign req_block    = 1'b0;
  assign wdog_err_int = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    cool_cnt_nxt   = cool_cnt;
    unique case (state)
      ST_IDLE: begin
        if (hs_req && !req_block) begin
          state_nxt      = ST_PAUSING;
          settle_cnt_nxt = SETTLE_LOAD;
        end
      end
      ST_PAUSING: begin
        if (!hs_req) begin
          state_nxt = ST_IDLE;
        end else if (settle_cnt == '0) begin
          state_nxt = ST_GRANT;
        end else begin
          settle_cnt_nxt = settle_cnt - SW'(1);
        end
      end
      ST_GRANT: begin
        if (!hs_req || wdog_expire) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt    = ST_COOLDOWN;
        cool_cnt_nxt = COOL_LOAD;
      end
      ST_COOLDOWN: begin
        if (cool_cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cool_cnt_nxt = cool_cnt - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      cool_cnt    <= '0;
      rvalid_q    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_cnt_nxt;
      cool_cnt    <= cool_cnt_nxt;
      rvalid_q    <= granted && !hs_we;
      collision_q <= collision_q || (granted && cpu_we);
    end
  end

  // Outputs are gated by reset so they read as idle for the whole reset window.
  always_comb begin
    granted   = (state == ST_GRANT);
    busy      = (state == ST_PAUSING) || (state == ST_GRANT) || (state == ST_RELEASE);
    hs_grant  = granted && !reset;
    cpu_pause = user_pause || (busy && !reset);
    if (granted) begin
      ram_addr  = hs_addr;
      ram_wdata = hs_wdata;
      ram_we    = hs_we && !reset;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we && (state != ST_RELEASE) && !reset;
    end
    hs_rvalid = rvalid_q && !reset;
    hs_rdata  = hs_rvalid ? ram_rdata : '0;
    collision = collision_q && !reset;
    wdog_err  = wdog_err_int && !reset;
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter: vector tables for the port mux
// plus hand-written sequences for grant timing, release, reset and watchdog.
module tb_hiscore_ram_arbiter;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        user_pause;
  logic        hs_req;
  logic [15:0] hs_addr;
  logic [7:0]  hs_wdata;
  logic        hs_we;
  logic        hs_grant;
  logic [7:0]  hs_rdata;
  logic        hs_rvalid;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = '0;
  logic        cpu_pause;
  logic        collision;
  logic        wdog_err;

  int errors = 0;
  int checks = 0;

  always #5 clk_49m = ~clk_49m;

  hiscore_ram_arbiter #(
    .SETTLE_CYCLES  (4),
    .MIN_CPU_CYCLES (16),
    .WDOG_CYCLES    (8)
  ) dut (
    .clk_49m    (clk_49m),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .user_pause (user_pause),
    .hs_req     (hs_req),
    .hs_addr    (hs_addr),
    .hs_wdata   (hs_wdata),
    .hs_we      (hs_we),
    .hs_grant   (hs_grant),
    .hs_rdata   (hs_rdata),
    .hs_rvalid  (hs_rvalid),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata),
    .cpu_pause  (cpu_pause),
    .collision  (collision),
    .wdog_err   (wdog_err)
  );

  // Synchronous RAM: data for the address of one cycle appears the next cycle.
  always @(posedge clk_49m) begin
    if (ram_addr == 16'h8800) ram_rdata <= 8'h5A;
    else                      ram_rdata <= ram_addr[15:8] ^ ram_addr[7:0];
  end

  typedef struct {
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        user_pause;
    logic [15:0] hs_addr;
    logic [7:0]  hs_wdata;
    logic        hs_we;
    logic [15:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_we;
    logic        exp_pause;
    logic        exp_rvalid;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t idle_tab[4];
  vec_t grant_tab[4];

  task automatic tick();
    @(posedge clk_49m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input int limit, output int n);
    n = 0;
    while (!hs_grant && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic apply(input vec_t v);
    cpu_addr   = v.cpu_addr;
    cpu_wdata  = v.cpu_wdata;
    cpu_we     = v.cpu_we;
    user_pause = v.user_pause;
    hs_addr    = v.hs_addr;
    hs_wdata   = v.hs_wdata;
    hs_we      = v.hs_we;
  endtask

  initial begin
    int n;
    int viol;

    //               cpu_addr  wd     we    up    hs_addr   wd     we    e_addr    e_wd   e_we  e_pz  rv    rd
    idle_tab[0]  = '{16'h1000, 8'hAA, 1'b1, 1'b0, 16'h8800, 8'h55, 1'b1, 16'h1000, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00};
    idle_tab[1]  = '{16'hFFFF, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h11, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    idle_tab[2]  = '{16'h0000, 8'hFF, 1'b1, 1'b1, 16'hFFFF, 8'h22, 1'b1, 16'h0000, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00};
    idle_tab[3]  = '{16'hC3C3, 8'h3C, 1'b0, 1'b0, 16'h1234, 8'h33, 1'b0, 16'hC3C3, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00};
    grant_tab[0] = '{16'h4000, 8'h99, 1'b0, 1'b0, 16'h1234, 8'h11, 1'b0, 16'h1234, 8'h11, 1'b0, 1'b1, 1'b1, 8'h26};
    grant_tab[1] = '{16'h4000, 8'h99, 1'b0, 1'b0, 16'h00FF, 8'h22, 1'b1, 16'h00FF, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00};
    grant_tab[2] = '{16'h4000, 8'h99, 1'b1, 1'b0, 16'hA55A, 8'h33, 1'b0, 16'hA55A, 8'h33, 1'b0, 1'b1, 1'b1, 8'hFF};
    grant_tab[3] = '{16'h4000, 8'h99, 1'b1, 1'b0, 16'h0F0F, 8'h44, 1'b1, 16'h0F0F, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00};

    reset = 1'b1; cpu_addr = 16'h2000; cpu_wdata = 8'h00; cpu_we = 1'b1;
    user_pause = 1'b0; hs_req = 1'b0; hs_addr = '0; hs_wdata = '0; hs_we = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_hs_grant",  hs_grant,  0);
    chk("rst_hs_rvalid", hs_rvalid, 0);
    chk("rst_hs_rdata",  hs_rdata,  0);
    chk("rst_ram_we",    ram_we,    0);
    chk("rst_collision", collision, 0);
    chk("rst_wdog_err",  wdog_err,  0);
    chk("rst_cpu_pause", cpu_pause, 0);
    user_pause = 1'b1;
    #1;
    chk("rst_cpu_pause_user", cpu_pause, 1);
    reset = 1'b0;

    // Idle: port follows the CPU, pause follows user_pause
    for (int i = 0; i < 4; i++) begin
      apply(idle_tab[i]);
      #1;
      chk("idle_ram_addr",  ram_addr,  idle_tab[i].exp_addr);
      chk("idle_ram_wdata", ram_wdata, idle_tab[i].exp_wdata);
      chk("idle_ram_we",    ram_we,    idle_tab[i].exp_we);
      chk("idle_cpu_pause", cpu_pause, idle_tab[i].exp_pause);
      tick();
      chk("idle_hs_rvalid", hs_rvalid, 0);
      chk("idle_hs_grant",  hs_grant,  0);
    end

    // hs_req rises in cycle 0: pause from cycle 1, grant at cycle 5
    cpu_addr = 16'h4000; cpu_we = 1'b0; user_pause = 1'b0;
    hs_addr = 16'h8800; hs_we = 1'b0; hs_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("settle_cpu_pause", cpu_pause, 1);
      chk("settle_hs_grant",  hs_grant,  (k == 5) ? 1 : 0);
      chk("settle_ram_addr",  ram_addr,  (k == 5) ? 32'h8800 : 32'h4000);
    end
    tick();
    chk("read_hs_rvalid", hs_rvalid, 1);
    chk("read_hs_rdata",  hs_rdata,  8'h5A);

    // Granted: port follows hs_*, CPU writes blocked
    for (int i = 0; i < 4; i++) begin
      apply(grant_tab[i]);
      #1;
      chk("grant_hs_grant",  hs_grant,  1);
      chk("grant_ram_addr",  ram_addr,  grant_tab[i].exp_addr);
      chk("grant_ram_wdata", ram_wdata, grant_tab[i].exp_wdata);
      chk("grant_ram_we",    ram_we,    grant_tab[i].exp_we);
      chk("grant_cpu_pause", cpu_pause, grant_tab[i].exp_pause);
      tick();
      chk("grant_hs_rvalid", hs_rvalid, grant_tab[i].exp_rvalid);
      chk("grant_hs_rdata",  hs_rdata,  grant_tab[i].exp_rdata);
    end
    chk("collision_set", collision, 1);

    // Release: one cycle, CPU write forced off, then 16-cycle cooldown
    hs_req = 1'b0; cpu_we = 1'b1;
    tick();
    chk("rel_hs_grant",  hs_grant,  0);
    chk("rel_cpu_pause", cpu_pause, 1);
    chk("rel_ram_we",    ram_we,    0);
    chk("rel_ram_addr",  ram_addr,  16'h4000);
    hs_req = 1'b1;
    n = 0; viol = 0;
    while (!hs_grant && n < 60) begin
      tick();
      n++;
      if (n <= 16 && (cpu_pause || !ram_we || hs_rvalid)) viol++;
    end
    chk("cooldown_cpu_owns_port", viol, 0);
    chk("regrant_latency", n, 22);
    chk("collision_sticky", collision, 1);

    // Reset during GRANT
    reset = 1'b1; user_pause = 1'b1;
    tick();
    chk("rstg_hs_grant",  hs_grant,  0);
    chk("rstg_cpu_pause", cpu_pause, 1);
    chk("rstg_collision", collision, 0);
    chk("rstg_ram_we",    ram_we,    0);
    user_pause = 1'b0;
    #1;
    chk("rstg_cpu_pause_user", cpu_pause, 0);
    reset = 1'b0; hs_req = 1'b0;
    #1;
    chk("rstg_no_release", cpu_pause, 0);
    chk("rstg_ram_we_cpu", ram_we,    1);
    tick();
    chk("rstg_idle_pause", cpu_pause, 0);
    chk("rstg_idle_grant", hs_grant,  0);

    // hs_req withdrawn while pausing
    hs_req = 1'b1;
    tick();
    tick();
    chk("abort_pausing", cpu_pause, 1);
    hs_req = 1'b0;
    tick();
    chk("abort_idle_pause", cpu_pause, 0);
    viol = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (hs_grant || cpu_pause) viol++;
    end
    chk("abort_no_grant", viol, 0);
    hs_req = 1'b1;
    wait_grant(40, n);
    chk("abort_full_settle", n, 5);

    // Reset during PAUSING clears the settle count
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rstp_pausing", cpu_pause, 1);
    reset = 1'b1;
    tick();
    chk("rstp_hs_grant",  hs_grant,  0);
    chk("rstp_cpu_pause", cpu_pause, 0);
    reset = 1'b0;
    wait_grant(40, n);
    chk("rstp_full_settle", n, 5);

`ifdef HS_ARB_WATCHDOG_EN
    // Held request: forced release after 8 grant cycles, no re-grant until hs_req falls
    reset = 1'b1; hs_req = 1'b0;
    tick();
    reset = 1'b0; hs_req = 1'b1; hs_we = 1'b0;
    wait_grant(40, n);
    chk("wdog_first_grant", n, 5);
    n = 0;
    while (hs_grant && n < 40) begin
      tick();
      n++;
    end
    chk("wdog_grant_len", n, 8);
    chk("wdog_err_set", wdog_err, 1);
    chk("wdog_release_pause", cpu_pause, 1);
    viol = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (hs_grant) viol++;
    end
    chk("wdog_no_regrant", viol, 0);
    hs_req = 1'b0;
    tick();
    hs_req = 1'b1;
    wait_grant(40, n);
    chk("wdog_regrant", n, 5);
    chk("wdog_err_sticky", wdog_err, 1);
`else
    chk("wdog_err_tied", wdog_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hiscore_ram_arbiter.md
HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles the CPU is held paused before the hiscore engine is granted the RAM port.
REQ-002 SHALL have parameter MIN_CPU_CYCLES, default 16: minimum cycles the CPU owns the port after a release before the next grant.
REQ-003 SHALL have parameter WDOG_CYCLES, default 65535: maximum grant duration, used only when the watchdog is compiled in.
REQ-004 SHALL have port clk_49m, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports cpu_addr (input, 16 bits), cpu_wdata (input, 8 bits) and cpu_we (input, 1 bit): the game CPU work-RAM request.
REQ-007 SHALL have port user_pause, input, 1 bit: the OSD/user pause request, passed through to cpu_pause.
REQ-008 SHALL have ports hs_req (input, 1 bit), hs_addr (input, 16 bits), hs_wdata (input, 8 bits) and hs_we (input, 1 bit): the hiscore engine request.
REQ-009 SHALL have ports hs_grant (output, 1 bit), hs_rdata (output, 8 bits) and hs_rvalid (output, 1 bit): the hiscore engine response.
REQ-010 SHALL have ports ram_addr (output, 16 bits), ram_wdata (output, 8 bits) and ram_we (output, 1 bit): the shared RAM port.
REQ-011 SHALL have port ram_rdata, input, 8 bits: RAM read data, valid 1 cycle after ram_addr.
REQ-012 SHALL have port cpu_pause, output, 1 bit: the CPU clock-enable hold.
REQ-013 SHALL have port collision, output, 1 bit: sticky flag, set on a CPU write while granted.
REQ-014 SHALL have port wdog_err, output, 1 bit: sticky watchdog-expiry flag.

Function
REQ-015 SHALL implement the FSM states IDLE, PAUSING, GRANT, RELEASE and COOLDOWN.
REQ-016 IDLE: SHALL move to PAUSING when hs_req=1; the RAM port SHALL mux the cpu_* inputs.
REQ-017 PAUSING: cpu_pause SHALL be 1 and a counter SHALL load SETTLE_CYCLES-1; SHALL enter GRANT the cycle after the counter reaches 0, giving hs_grant exactly SETTLE_CYCLES+1 cycles after hs_req rises.
REQ-018 PAUSING: if hs_req drops, SHALL return to IDLE next cycle with no grant.
REQ-019 GRANT: hs_grant and cpu_pause SHALL be 1; the RAM port SHALL mux the hs_* inputs, and ram_we SHALL equal hs_we in the same cycle (combinational mux, registered select).
REQ-020 GRANT: hs_rvalid SHALL pulse 1 cycle after each granted non-write cycle, with hs_rdata = registered ram_rdata.
REQ-021 GRANT: SHALL go to RELEASE when hs_req=0.
REQ-022 RELEASE: SHALL last exactly 1 cycle, with hs_grant=0, cpu_pause=1 and the RAM port on cpu_* with ram_we forced to 0; then SHALL enter COOLDOWN.
REQ-023 COOLDOWN: SHALL count MIN_CPU_CYCLES with cpu_pause released; a pending hs_req SHALL wait; then SHALL enter IDLE.
REQ-024 cpu_pause SHALL equal user_pause OR (state is PAUSING, GRANT or RELEASE), with no added latency on user_pause.
REQ-025 cpu_we=1 during GRANT SHALL be blocked from ram_we and SHALL set collision, which clears only on reset.
REQ-026 Counters SHALL be sized to clog2 of the parameter, with a minimum width of 1; SETTLE_CYCLES=0 SHALL behave as 1.
REQ-027 hs_rvalid SHALL never assert outside GRANT or the first cycle after it.

Reset
REQ-028 While reset=1 the block SHALL enter IDLE next edge and clear every counter.
REQ-029 While reset=1 outputs SHALL be: hs_grant=0, hs_rvalid=0, hs_rdata=0, ram_we=0, collision=0, wdog_err=0, and cpu_pause=user_pause.
REQ-030 Reset during GRANT SHALL drop the grant at the next edge, with no RELEASE or COOLDOWN pass.

Configuration
REQ-031 SHALL compile the grant watchdog in only when macro HS_ARB_WATCHDOG_EN is defined: a GRANT longer than WDOG_CYCLES forces RELEASE and sets wdog_err, and hs_req must then fall before a new request is accepted.
REQ-032 Without HS_ARB_WATCHDOG_EN, GRANT SHALL be unbounded and wdog_err SHALL be tied to 0.

Structure
REQ-033 Package hs_arb_pkg SHALL hold the state enum type and the default parameter constants.
REQ-034 The watchdog counter SHALL be the single sub-module hs_arb_watchdog, instantiated only under HS_ARB_WATCHDOG_EN.

Verification
REQ-035 hs_req rises at cycle 0 with SETTLE=4 -> cpu_pause=1 at cycle 1, hs_grant=1 at cycle 5, ram_addr=hs_addr from cycle 5.
REQ-036 Granted read at hs_addr=16'h8800 with RAM returning 8'h5A -> hs_rvalid=1 and hs_rdata=8'h5A 1 cycle later.
REQ-037 hs_req drops in GRANT -> 1 RELEASE cycle with ram_we=0, then cpu_pause=0; an immediate re-request is granted no earlier than 16+5 cycles later.
REQ-038 cpu_we=1 in GRANT -> ram_we=hs_we and collision latches 1; reset clears it to 0.
REQ-039 Reset in PAUSING or GRANT -> next edge hs_grant=0, state IDLE, cpu_pause=user_pause.
REQ-040 With HS_ARB_WATCHDOG_EN and WDOG_CYCLES=8, hs_req held high -> forced release after 8 grant cycles, wdog_err=1, no re-grant until hs_req falls.
